// File: rtl/sorter_pkg.sv
// Shared types and constants for the sorter job scheduler slice.
//   SCHED_NUM_REQ : default requester count; ID_W is sized from it, so any
//                   NUM_REQ override must not exceed 2**ID_W.
//   ID_W          : width of a requester id.
//   sched_tag_t   : {valid, id, err} tag travelling alongside each sorter job.
package sorter_pkg;

    localparam int unsigned SCHED_NUM_REQ = 4;
    localparam int unsigned ID_W = (SCHED_NUM_REQ > 1) ? $clog2(SCHED_NUM_REQ) : 1;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            err;
    } sched_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants at most one requester per cycle. The search
// starts at the pointer; after a grant the pointer moves to the granted
// index + 1 (mod NUM_REQ). Without a grant the pointer holds.
//   clk_i, rst_i : clock, async active-high reset (pointer -> 0)
//   req_i        : eligible requesters
//   grant_o      : one-hot grant
//   grant_any_o  : a grant was issued this cycle
//   grant_id_o   : encoded index of the granted requester (0 when none)
module rr_arbiter
    import sorter_pkg::*;
#(
    parameter int unsigned NUM_REQ = SCHED_NUM_REQ
)
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               grant_any_o,
    output logic [ID_W-1:0]    grant_id_o
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_o     = '0;
        grant_any_o = 1'b0;
        grant_id_o  = '0;
        ptr_d       = ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any_o && req_i[ID_W'(idx)]) begin
                grant_o[ID_W'(idx)] = 1'b1;
                grant_any_o         = 1'b1;
                grant_id_o          = ID_W'(idx);
                ptr_d               = (idx + 1 == NUM_REQ) ? '0 : ID_W'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sorter_job_scheduler.sv
// Shares one pipelined sorter between NUM_REQ requesters.
//   clk_i, rst_i      : clock, async active-high reset
//   req_valid_i       : job request per requester
//   req_ready_o       : job accepted this cycle (one-hot, granted index)
//   req_sign_i        : signed-compare flag per requester
//   req_len_i         : element count per requester
//   req_data_i        : operands per requester
//   sort_sign_ctrl_o, sort_len_o, sort_x_o : registered sorter inputs
//   res_valid_o       : current sorter output slot belongs to a job
//   res_id_o          : owning requester of that slot
//   res_err_o         : job had an illegal length; sorter data meaningless
//   busy_o            : any job in flight
// A job granted in cycle N drives the sorter in N+1 and its tag appears on
// res_* in N+1+SORT_LATENCY. Each requester may have up to MAX_OUTSTANDING
// jobs in flight.
module sorter_job_scheduler
    import sorter_pkg::*;
#(
    parameter int unsigned NUM_REQ         = SCHED_NUM_REQ,
    parameter int unsigned DATAWIDTH       = 8,
    parameter int unsigned MAX_DATALENGTH  = 32,
    parameter int unsigned SORT_LATENCY    = 5,
    parameter int unsigned MAX_OUTSTANDING = 2
)
(
    input  logic                                                  clk_i,
    input  logic                                                  rst_i,
    input  logic [NUM_REQ-1:0]                                    req_valid_i,
    output logic [NUM_REQ-1:0]                                    req_ready_o,
    input  logic [NUM_REQ-1:0]                                    req_sign_i,
    input  logic [NUM_REQ-1:0][5:0]                               req_len_i,
    input  logic [NUM_REQ-1:0][MAX_DATALENGTH-1:0][DATAWIDTH-1:0] req_data_i,
    output logic                                                  sort_sign_ctrl_o,
    output logic [5:0]                                            sort_len_o,
    output logic [MAX_DATALENGTH-1:0][DATAWIDTH-1:0]              sort_x_o,
    output logic                                                  res_valid_o,
    output logic [ID_W-1:0]                                       res_id_o,
    output logic                                                  res_err_o,
    output logic                                                  busy_o
);

    localparam int unsigned          CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_REQ-1:0]        eligible;
    logic [NUM_REQ-1:0]        retire;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        cnt_busy;
    logic                      grant_any;
    logic [ID_W-1:0]           grant_id;
    logic [5:0]                len_sel;
    logic                      len_ok;
    sched_tag_t                new_tag;
    sched_tag_t [SORT_LATENCY:0] tag_q;
    logic [SORT_LATENCY:0]     tag_valid;

    // Per-requester in-flight accounting.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        logic [CNT_W-1:0] cnt_q;

        assign retire[i]   = tag_q[SORT_LATENCY].valid &&
                             (tag_q[SORT_LATENCY].id == ID_W'(i));
        // A slot retiring this cycle is already free, so a requester at its
        // limit can still be granted; the counter then holds its value.
        assign eligible[i] = req_valid_i[i] && ((cnt_q < CNT_MAX) || retire[i]);
        assign cnt_busy[i] = |cnt_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else if (grant[i] && !retire[i]) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (retire[i] && !grant[i]) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (eligible),
        .grant_o     (grant),
        .grant_any_o (grant_any),
        .grant_id_o  (grant_id)
    );

    assign req_ready_o = grant;
    assign len_sel     = req_len_i[grant_id];
    assign len_ok      = (len_sel != 6'd0) && ({26'd0, len_sel} <= MAX_DATALENGTH);

    always_comb begin
        new_tag       = '0;
        new_tag.valid = grant_any;
        new_tag.id    = grant_id;
        new_tag.err   = grant_any && !len_ok;
    end

    // Rejected (bad length) jobs still occupy a slot but present an idle
    // sorter input.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sort_sign_ctrl_o <= 1'b0;
            sort_len_o       <= '0;
            sort_x_o         <= '0;
        end else if (grant_any && len_ok) begin
            sort_sign_ctrl_o <= req_sign_i[grant_id];
            sort_len_o       <= len_sel;
            sort_x_o         <= req_data_i[grant_id];
        end else begin
            sort_sign_ctrl_o <= 1'b0;
            sort_len_o       <= '0;
            sort_x_o         <= '0;
        end
    end

    // Stage 0 is aligned with sort_*; stage SORT_LATENCY with the sorter result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q <= '0;
        end else begin
            tag_q <= {tag_q[SORT_LATENCY-1:0], new_tag};
        end
    end

    for (genvar s = 0; s <= SORT_LATENCY; s++) begin : g_tagv
        assign tag_valid[s] = tag_q[s].valid;
    end

    assign res_valid_o = tag_q[SORT_LATENCY].valid;
    assign res_id_o    = tag_q[SORT_LATENCY].id;
    assign res_err_o   = tag_q[SORT_LATENCY].err;
    assign busy_o      = (|tag_valid) || (|cnt_busy);

endmodule

// File: tb/tb_sorter_job_scheduler.sv
`timescale 1ns/1ps
module tb_sorter_job_scheduler;
    import sorter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int ML = 32;
    localparam int L  = 5;
    localparam int MO = 2;

    typedef logic [ML-1:0][DW-1:0]        vec_t;
    typedef logic [N-1:0][ML-1:0][DW-1:0] data_t;
    typedef logic [N-1:0][5:0]            len_t;

    typedef struct {
        int         cyc;
        logic [5:0] len;
        logic       sign;
        vec_t       x;
    } sort_exp_t;

    typedef struct {
        int   id;
        logic err;
        int   due;
    } res_exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_sign = '0;
    len_t            req_len = '0;
    data_t           req_data = '0;
    logic            sort_sign;
    logic [5:0]      sort_len;
    vec_t            sort_x;
    logic            res_valid;
    logic [ID_W-1:0] res_id;
    logic            res_err;
    logic            busy;

    sorter_job_scheduler #(
        .NUM_REQ         (N),
        .DATAWIDTH       (DW),
        .MAX_DATALENGTH  (ML),
        .SORT_LATENCY    (L),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_sign_i       (req_sign),
        .req_len_i        (req_len),
        .req_data_i       (req_data),
        .sort_sign_ctrl_o (sort_sign),
        .sort_len_o       (sort_len),
        .sort_x_o         (sort_x),
        .res_valid_o      (res_valid),
        .res_id_o         (res_id),
        .res_err_o        (res_err),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int err_seen = 0;
    int rr_ptr   = 0;
    sort_exp_t sort_q[$];
    res_exp_t  res_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(posedge clk) begin
        sort_exp_t se;
        res_exp_t  re;
        cyc++;
        #2;
        check("busy", busy, res_q.size() > 0);
        if (sort_q.size() > 0 && sort_q[0].cyc == cyc) begin
            se = sort_q.pop_front();
            check("sort_len", sort_len, se.len);
            check("sort_sign", sort_sign, se.sign);
            check("sort_x", sort_x, se.x);
        end
        if (res_valid) begin
            if (res_q.size() == 0) begin
                check("res_valid_unexpected", res_valid, 1'b0);
            end else begin
                re = res_q.pop_front();
                check("res_cycle", cyc, re.due);
                check("res_id", res_id, re.id);
                check("res_err", res_err, re.err);
                if (res_err) err_seen++;
            end
        end else if (res_q.size() > 0 && res_q[0].due <= cyc) begin
            check("res_valid_missing", res_valid, 1'b1);
            void'(res_q.pop_front());
        end
    end

    // One cycle of stimulus; the reference model predicts the grant from the
    // requester occupancy implied by the scoreboard contents.
    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] s, input len_t l,
                         input data_t d, output int dut_g);
        int         cnt [N];
        int         g;
        logic       ok;
        logic [N-1:0] exp_rdy;
        sort_exp_t  se;
        res_exp_t   re;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = v;
        req_sign  = s;
        req_len   = l;
        req_data  = d;
        #1;
        foreach (cnt[k]) cnt[k] = 0;
        foreach (res_q[k]) if (res_q[k].due > cyc) cnt[res_q[k].id]++;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (rr_ptr + k) % N;
            if (g < 0 && v[idx] && cnt[idx] < MO) g = idx;
        end
        dut_g = -1;
        for (int k = 0; k < N; k++) if (req_ready[k]) dut_g = k;
        exp_rdy = '0;
        se.cyc  = cyc + 1;
        se.len  = '0;
        se.sign = 1'b0;
        se.x    = '0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            rr_ptr     = (g + 1) % N;
            ok         = (l[g] >= 1) && (l[g] <= ML);
            if (ok) begin
                se.len  = l[g];
                se.sign = s[g];
                se.x    = d[g];
            end
            re.id  = g;
            re.err = !ok;
            re.due = cyc + 1 + L;
            res_q.push_back(re);
        end
        sort_q.push_back(se);
        check("ready", req_ready, exp_rdy);
    endtask

    task automatic idle(input int n);
        int g;
        for (int i = 0; i < n; i++) drive('0, '0, '0, '0, g);
    endtask

    task automatic drain();
        int g;
        for (int i = 0; i < 40 && res_q.size() > 0; i++) drive('0, '0, '0, '0, g);
        check("drain_empty", res_q.size(), 0);
    endtask

    // Leaves rst asserted; the next drive() releases it on the same edge
    // that presents the first request.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        sort_q.delete();
        res_q.delete();
        rr_ptr    = 0;
        #1;
        check("rst_ready", req_ready, '0);
        check("rst_sort_len", sort_len, '0);
        check("rst_sort_sign", sort_sign, 1'b0);
        check("rst_sort_x", sort_x, '0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_id", res_id, '0);
        check("rst_res_err", res_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    function automatic data_t rand_data();
        data_t d;
        for (int r = 0; r < N; r++)
            for (int e = 0; e < ML; e++) d[r][e] = 8'($urandom);
        return d;
    endfunction

    initial begin
        int     g;
        int     exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int     base;
        len_t   l;
        data_t  d;
        logic [N-1:0] v;
        logic [N-1:0] s;

        do_reset();

        // All four requesters continuously valid: strict rotation.
        l = '{default: 6'd4};
        for (int c = 0; c < 12; c++) begin
            drive(4'b1111, $urandom, l, rand_data(), g);
            if (c < 8) check("rr_order", g, exp_order[c]);
        end
        drain();

        // Requester 0, full length, ascending odd data.
        d = '0;
        for (int e = 0; e < ML; e++) d[0][e] = 8'(5 + 2 * e);
        l = '0;
        l[0] = 6'd32;
        drive(4'b0001, 4'b0000, l, d, g);
        check("req31_grant", g, 0);
        drain();

        // Illegal lengths 0 and 33 from requester 2.
        base = err_seen;
        l = '0;
        l[2] = 6'd0;
        drive(4'b0100, 4'b0100, l, rand_data(), g);
        l[2] = 6'd33;
        drive(4'b0100, 4'b0100, l, rand_data(), g);
        drain();
        check("bad_len_errors", err_seen - base, 2);

        // Requester 1 alone: two grants, then held off until a retire frees
        // a slot in the same cycle as a new grant.
        l = '0;
        l[1] = 6'd8;
        for (int c = 0; c < 14; c++) begin
            drive(4'b0010, 4'b0000, l, rand_data(), g);
            check("outstanding_gate", g,
                  (c == 0 || c == 1 || c == 6 || c == 7 || c == 12 || c == 13) ? 1 : -1);
        end
        drain();

        // Signed len 19 then unsigned len 8 back-to-back.
        l = '0;
        l[0] = 6'd19;
        l[1] = 6'd8;
        drive(4'b0001, 4'b0001, l, rand_data(), g);
        drive(4'b0010, 4'b0000, l, rand_data(), g);
        drain();

        // Randomised traffic, including illegal lengths on some requests.
        for (int c = 0; c < 300; c++) begin
            v = 4'($urandom);
            s = 4'($urandom);
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(0, 7) == 0)
                    l[r] = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(33, 63));
                else
                    l[r] = 6'($urandom_range(1, 32));
            end
            drive(v, s, l, rand_data(), g);
        end
        drain();

        // Reset with three jobs in flight; they must never surface.
        l = '{default: 6'd10};
        for (int c = 0; c < 3; c++) drive(4'b0111, 4'b0000, l, rand_data(), g);
        do_reset();
        check("post_rst_busy", busy, 1'b0);
        drive(4'b1000, 4'b0000, l, rand_data(), g);
        check("first_edge_grant", g, 3);
        idle(10);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sorter_job_scheduler.md
SORTER_JOB_SCHEDULER -- requirements
Module: sorter_job_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters.
REQ-002 SHALL have parameter DATAWIDTH, default 8, element width.
REQ-003 SHALL have parameter MAX_DATALENGTH, default 32, elements per job.
REQ-004 SHALL have parameter SORT_LATENCY, default 5, sorter pipeline depth in cycles (issue to result).
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 2, in-flight jobs per requester.
REQ-006 SHALL have ports: clk_i  in  1  clock; one clock; all logic on rising edge.
REQ-007 SHALL have ports: rst_i  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports: req_valid_i  in  NUM_REQ  job request per requester.
REQ-009 SHALL have ports: req_ready_o  out  NUM_REQ  job accepted this cycle.
REQ-010 SHALL have ports: req_sign_i  in  NUM_REQ  signed-compare flag per requester.
REQ-011 SHALL have ports: req_len_i  in  NUM_REQ x 6  element count per requester.
REQ-012 SHALL have ports: req_data_i  in  NUM_REQ x MAX_DATALENGTH x DATAWIDTH  job operands.
REQ-013 SHALL have ports: sort_sign_ctrl_o, sort_len_o (6), sort_x_o (MAX_DATALENGTH x DATAWIDTH)  out  drive sorter inputs.
REQ-014 SHALL have ports: res_valid_o  out  1  sorter output slot belongs to a job.
REQ-015 SHALL have ports: res_id_o  out  clog2(NUM_REQ)  owning requester.
REQ-016 SHALL have ports: res_err_o  out  1  job rejected (bad length), sorter data invalid.
REQ-017 SHALL have ports: busy_o  out  1  any job in flight.

Function
REQ-018 SHALL grant at most one requester per cycle, round-robin; pointer moves to granted index + 1 (mod NUM_REQ); no grant leaves pointer unchanged.
REQ-019 SHALL be eligible only if req_valid_i[i] and outstanding[i] < MAX_OUTSTANDING; req_ready_o[i] high only for granted index; handshake = valid & ready same cycle.
REQ-020 SHALL register sorter inputs: job granted in cycle N appears on sort_* in cycle N+1; with no grant, sort_len_o=0, sort_sign_ctrl_o=0, sort_x_o all zero.
REQ-021 SHALL treat length valid iff 1 <= len <= MAX_DATALENGTH; invalid job is accepted, sort_* driven as idle, res_err_o=1 at its slot.
REQ-022 SHALL carry {valid, id, err} through a SORT_LATENCY-deep tag shift register; res_* for job granted in cycle N asserted in cycle N+1+SORT_LATENCY, one cycle.
REQ-023 SHALL increment outstanding[i] on grant, decrement on res_valid_o for id i; simultaneous grant and retire of same i: unchanged; never exceeds MAX_OUTSTANDING nor underflows.
REQ-024 SHALL preserve per-requester result order equal to acceptance order; back-to-back grants every cycle permitted (full throughput).
REQ-025 SHALL hold busy_o high while any tag stage valid or any outstanding counter nonzero.
REQ-026 SHALL ignore req_len_i/req_data_i of non-granted requesters; inputs need not be stable while ready low.

Reset
REQ-027 SHALL on rst_i: all outputs 0, tag pipeline cleared, counters 0, RR pointer 0; in-flight jobs dropped, no res_valid_o for them after release.
REQ-028 SHALL accept first grant in first rising edge with rst_i low.

Structure
REQ-029 SHALL put sched_tag_t {valid, id, err} and ID_W constant in shared package sorter_pkg.
REQ-030 SHALL implement arbitration in one sub-module rr_arbiter (NUM_REQ req in, one-hot grant out, pointer state).

Verification
REQ-031 SHALL: req0 valid, len 32, unsigned data {5,7,9,...}, cycle 0 -> sort_len_o=32 cycle 1; res_valid_o=1, res_id_o=0 cycle 6.
REQ-032 SHALL: all 4 valid continuously -> grants 0,1,2,3,0,1,2,3; each requester then blocked after 2 grants until its results retire.
REQ-033 SHALL: req2 len 0 and len 33 -> both accepted, sort_len_o=0, res_err_o=1 with res_id_o=2 at slot.
REQ-034 SHALL: req1 at MAX_OUTSTANDING, result retires same cycle as new valid -> grant taken, counter stays 2.
REQ-035 SHALL: rst_i pulsed with 3 jobs in flight -> res_valid_o stays 0, busy_o=0, counters 0 after reset.
REQ-036 SHALL: signed job len 19 then unsigned len 8 back-to-back -> sort_sign_ctrl_o 1 then 0 on consecutive cycles, results in order.
